// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared fetch-stage constants, state encoding and PC helper
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    // Encodings are shared with the decode-side bubble logic, so keep them fixed.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_hold_buffer.sv
// rtl/if_hold_buffer.sv - one-entry skid register for a fetch response caught by a stall
module if_hold_buffer
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc_next,
    output logic        valid,
    output logic        valid_next,
    output logic [31:0] instr,
    output logic [31:0] pc_next
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_next_q, pc_next_d;

    // valid_next lets the fetch FSM refuse to issue when the entry will still be occupied.
    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        pc_next_d = pc_next_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d   = 1'b1;
            instr_d   = load_instr;
            pc_next_d = load_pc_next;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            instr_q   <= NOP_INSTR;
            pc_next_q <= 32'h0;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            pc_next_q <= pc_next_d;
        end
    end

    assign valid      = valid_q;
    assign valid_next = valid_d;
    assign instr      = instr_q;
    assign pc_next    = pc_next_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC, single-outstanding imem request, IF/ID register
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_next
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  issued_addr_q, issued_addr_d;
    logic [31:0]  if_id_instr_q, if_id_instr_d;
    logic [31:0]  if_id_pcn_q, if_id_pcn_d;

    logic        rsp_accept, slot_free, issue;
    logic        hold_load, hold_drain;
    logic        hold_valid, hold_valid_next;
    logic [31:0] hold_instr, hold_pc_next;

    if_hold_buffer #(.NOP_INSTR(NOP_INSTR)) u_hold (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (hold_load),
        .drain        (hold_drain),
        .clear        (redirect_valid),
        .load_instr   (imem_rdata),
        .load_pc_next (pc_plus4(issued_addr_q)),
        .valid        (hold_valid),
        .valid_next   (hold_valid_next),
        .instr        (hold_instr),
        .pc_next      (hold_pc_next)
    );

    always_comb begin
        rsp_accept = imem_rvalid && (state_q == S_WAIT) && !redirect_valid;
        slot_free  = (state_q == S_IDLE) ||
                     (imem_rvalid && (state_q == S_WAIT || state_q == S_KILL));
        hold_load  = stall && !redirect_valid && rsp_accept;
        hold_drain = !stall && !redirect_valid;
        // A request is a combinational pulse so a 1-cycle memory sustains one fetch per cycle.
        issue      = rst_n && slot_free && !redirect_valid && !hold_valid_next;
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        issued_addr_d = issued_addr_q;
        if (issue) begin
            state_d       = S_WAIT;
            fetch_pc_d    = pc_plus4(fetch_pc_q);
            issued_addr_d = fetch_pc_q;
        end else if (slot_free) begin
            state_d = S_IDLE;
        end else if (state_q == S_WAIT && redirect_valid) begin
            state_d = S_KILL;
        end
        if (redirect_valid) begin
            fetch_pc_d = {redirect_target[31:2], 2'b00};
        end
    end

    always_comb begin
        if_id_instr_d = NOP_INSTR;
        if_id_pcn_d   = 32'h0;
        if (redirect_valid) begin
            if_id_instr_d = NOP_INSTR;
            if_id_pcn_d   = 32'h0;
        end else if (stall) begin
            if_id_instr_d = if_id_instr_q;
            if_id_pcn_d   = if_id_pcn_q;
        end else if (hold_valid) begin
            if_id_instr_d = hold_instr;
            if_id_pcn_d   = hold_pc_next;
        end else if (rsp_accept) begin
            if_id_instr_d = imem_rdata;
            if_id_pcn_d   = pc_plus4(issued_addr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            issued_addr_q <= 32'h0;
            if_id_instr_q <= NOP_INSTR;
            if_id_pcn_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            issued_addr_q <= issued_addr_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pcn_q   <= if_id_pcn_d;
        end
    end

    assign imem_req          = issue;
    assign imem_addr         = issue ? fetch_pc_q : 32'h0;
    assign if_id_instruction = if_id_instr_q;
    assign if_id_pc_next     = if_id_pcn_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] if_id_instruction, if_id_pc_next;

    logic        hi_req, hi_rvalid;
    logic [31:0] hi_addr, hi_rdata, hi_instr, hi_pcn;
    logic        hi_req_s = 1'b0;
    logic [31:0] hi_addr_s = 32'h0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_stage u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_next     (if_id_pc_next)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (1'b0),
        .redirect_valid    (1'b0),
        .redirect_target   (32'h0),
        .imem_req          (hi_req),
        .imem_addr         (hi_addr),
        .imem_rvalid       (hi_rvalid),
        .imem_rdata        (hi_rdata),
        .if_id_instruction (hi_instr),
        .if_id_pc_next     (hi_pcn)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Memory model: returns the address as the instruction after mem_lat cycles.
    bit          mem_auto = 1'b1;
    int          mem_lat  = 1;
    int          cyc      = 0;
    int          due      = -1;
    logic [31:0] paddr    = 32'h0;
    logic        man_rv   = 1'b0;
    logic [31:0] man_rd   = 32'h0;

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!mem_auto) begin
                imem_rvalid = man_rv;
                imem_rdata  = man_rd;
            end else if (cyc == due) begin
                imem_rvalid = 1'b1;
                imem_rdata  = paddr;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) due = -1;
        else if (imem_req) begin
            paddr = imem_addr;
            due   = cyc + mem_lat;
        end
    end

    initial begin
        hi_rvalid = 1'b0;
        hi_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            hi_rvalid = hi_req_s;
            hi_rdata  = hi_addr_s;
        end
    end

    initial forever begin
        @(negedge clk);
        hi_req_s  = hi_req && rst_n;
        hi_addr_s = hi_addr;
    end

    // Request scoreboard: expected addresses queued by the test, popped per observed request.
    logic [31:0] exp_q[$];
    bit          sb_on = 1'b0;

    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (sb_on && rst_n && imem_req) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_req: got request %h expected none", imem_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (imem_addr !== e) begin
                        errors++;
                        $display("FAIL sb_req: got addr %h expected %h", imem_addr, e);
                    end
                end
            end
        end
    end

    task automatic tick(input logic s, input logic r, input logic [31:0] t,
                        input logic rv = 1'b0, input logic [31:0] rd = 32'h0);
        @(posedge clk);
        man_rv = rv;
        man_rd = rd;
        #1;
        stall           = s;
        redirect_valid  = r;
        redirect_target = t;
        @(negedge clk);
        #1;
    endtask

    // Ends at the negedge of the first cycle after release (cycle 0).
    task automatic do_reset(input bit check_rst, input logic late_rv);
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        #1;
        if (check_rst) begin
            chk("rst_instr", if_id_instruction, 32'h0);
            chk("rst_pcn",   if_id_pc_next,     32'h0);
            chk("rst_req",   imem_req,          1'b0);
            chk("rst_addr",  imem_addr,         32'h0);
        end
        repeat (2) @(posedge clk);
        man_rv = late_rv;
        man_rd = 32'hBAD0_0000;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic sb_close(input string name);
        sb_on = 1'b0;
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    typedef struct {
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_pcn;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit found;
        vecs[0] = '{1'b0, 1'b1, 32'h04, 32'h00, 32'h00};
        vecs[1] = '{1'b0, 1'b1, 32'h08, 32'h00, 32'h04};
        vecs[2] = '{1'b1, 1'b0, 32'h00, 32'h04, 32'h08};
        vecs[3] = '{1'b1, 1'b0, 32'h00, 32'h04, 32'h08};
        vecs[4] = '{1'b1, 1'b0, 32'h00, 32'h04, 32'h08};
        vecs[5] = '{1'b0, 1'b1, 32'h0C, 32'h04, 32'h08};
        vecs[6] = '{1'b0, 1'b1, 32'h10, 32'h08, 32'h0C};

        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;

        // 1-cycle memory back-to-back, then a 3-cycle stall catching the fetch of 0x8.
        mem_lat = 1;
        exp_q.push_back(32'h0);
        sb_on = 1'b1;
        do_reset(1'b1, 1'b0);
        chk("t1_c0_instr", if_id_instruction, 32'h0);
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].exp_req) exp_q.push_back(vecs[i].exp_addr);
            tick(vecs[i].stall, 1'b0, 32'h0);
            chk($sformatf("t12_req_%0d", i + 1),   imem_req,          vecs[i].exp_req);
            chk($sformatf("t12_instr_%0d", i + 1), if_id_instruction, vecs[i].exp_instr);
            chk($sformatf("t12_pcn_%0d", i + 1),   if_id_pc_next,     vecs[i].exp_pcn);
        end
        tick(1'b1, 1'b0, 32'h0);
        chk("t12_instr_8", if_id_instruction, 32'h0C);
        chk("t12_pcn_8",   if_id_pc_next,     32'h10);
        chk("t12_req_8",   imem_req,          1'b0);
        sb_close("t12_sb_empty");

        // 3-cycle memory, redirect while the fetch of 0x10 is outstanding.
        mem_lat = 3;
        foreach (vecs[i]) begin end
        exp_q.push_back(32'h000); exp_q.push_back(32'h004); exp_q.push_back(32'h008);
        exp_q.push_back(32'h00C); exp_q.push_back(32'h010); exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        sb_on = 1'b1;
        do_reset(1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (imem_req && imem_addr == 32'h10) found = 1'b1;
        end
        chk("t3_reach_req10", found, 1'b1);
        tick(1'b0, 1'b1, 32'h100);
        chk("t3_instr_before", if_id_instruction, 32'h0C);
        chk("t3_req_on_redir", imem_req, 1'b0);
        tick(1'b0, 1'b0, 32'h0);
        chk("t3_flush_instr", if_id_instruction, 32'h0);
        chk("t3_flush_pcn",   if_id_pc_next,     32'h0);
        chk("t3_req_kill",    imem_req,          1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (if_id_instruction != 32'h0) found = 1'b1;
        end
        chk("t3_resp_seen", found, 1'b1);
        chk("t3_instr", if_id_instruction, 32'h100);
        chk("t3_pcn",   if_id_pc_next,     32'h104);
        sb_close("t3_sb_empty");

        // Redirect coinciding with rvalid and stall.
        mem_lat = 1;
        exp_q.push_back(32'h000); exp_q.push_back(32'h004); exp_q.push_back(32'h008);
        exp_q.push_back(32'h200); exp_q.push_back(32'h204);
        sb_on = 1'b1;
        do_reset(1'b0, 1'b0);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        chk("t4_pre_instr", if_id_instruction, 32'h0);
        chk("t4_pre_pcn",   if_id_pc_next,     32'h4);
        tick(1'b1, 1'b1, 32'h202);
        chk("t4_req_redir", imem_req, 1'b0);
        tick(1'b0, 1'b0, 32'h0);
        chk("t4_flush_instr", if_id_instruction, 32'h0);
        chk("t4_flush_pcn",   if_id_pc_next,     32'h0);
        chk("t4_req_new",     imem_req,          1'b1);
        tick(1'b0, 1'b0, 32'h0);
        chk("t4_no_hold_instr", if_id_instruction, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        chk("t4_tgt_instr", if_id_instruction, 32'h200);
        chk("t4_tgt_pcn",   if_id_pc_next,     32'h204);
        sb_close("t4_sb_empty");

        // Wrap of the PC on the instance reset to FFFF_FFF8.
        do_reset(1'b0, 1'b0);
        chk("t5_req0_addr", hi_addr, 32'hFFFF_FFF8);
        tick(1'b0, 1'b0, 32'h0);
        chk("t5_req1_addr", hi_addr, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 32'h0);
        chk("t5_req2_addr", hi_addr, 32'h0000_0000);
        chk("t5_instr_a",   hi_instr, 32'hFFFF_FFF8);
        chk("t5_pcn_a",     hi_pcn,   32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 32'h0);
        chk("t5_instr_b",   hi_instr, 32'hFFFF_FFFC);
        chk("t5_pcn_b",     hi_pcn,   32'h0000_0000);

        // Reset while waiting; a stray rvalid right after release must be ignored.
        mem_auto = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        sb_on = 1'b1;
        do_reset(1'b0, 1'b0);
        tick(1'b0, 1'b0, 32'h0);
        do_reset(1'b1, 1'b1);
        chk("t6_req_after_rst", imem_req, 1'b1);
        tick(1'b0, 1'b0, 32'h0);
        chk("t6_stray_instr", if_id_instruction, 32'h0);
        chk("t6_stray_pcn",   if_id_pc_next,     32'h0);
        chk("t6_req_wait",    imem_req,          1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
        chk("t6_nop_instr", if_id_instruction, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        chk("t6_instr", if_id_instruction, 32'h1234_5678);
        chk("t6_pcn",   if_id_pc_next,     32'h4);
        sb_close("t6_sb_empty");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
